// File: rtl/nv_nvdla_csb2apb_pkg.sv
// Shared types and constants for the CSB-to-APB bridge.
package nv_nvdla_csb2apb_pkg;

    localparam int unsigned CSB_ADDR_W = 16;
    localparam int unsigned APB_ADDR_W = 32;
    localparam int unsigned DATA_W     = 32;

    // Bridge sequencing: one APB3 transfer per accepted CSB request.
    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StSetup  = 2'd1,
        StAccess = 2'd2
    } state_t;

    // CSB addresses are word addresses; APB wants a byte address.
    function automatic logic [APB_ADDR_W-1:0] csb_to_paddr(
        input logic [APB_ADDR_W-1:0] base,
        input logic [CSB_ADDR_W-1:0] addr
    );
        return base | {{(APB_ADDR_W - CSB_ADDR_W - 2){1'b0}}, addr, 2'b00};
    endfunction

endpackage

// File: rtl/nv_nvdla_csb2apb_tmo.sv
// Access-phase timeout counter for the CSB-to-APB bridge.
module nv_nvdla_csb2apb_tmo #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned TO_W           = 8
) (
    input  logic pclk,
    input  logic prstn,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [TO_W-1:0] count;

    // Loads 1 ahead of the first access cycle, then counts access cycles (saturating).
    always_ff @(posedge pclk) begin
        if (!prstn) begin
            count <= '0;
        end else if (clear) begin
            count <= TO_W'(1);
        end else if (enable && (count != '1)) begin
            count <= count + TO_W'(1);
        end
    end

    // A zero limit disables the timeout entirely.
    assign expired = (TIMEOUT_CYCLES != 0) && (count == TO_W'(TIMEOUT_CYCLES));

endmodule

// File: rtl/nv_nvdla_csb2apb.sv
// CSB-to-APB3 bridge: one outstanding transaction, registered responses.
module nv_nvdla_csb2apb
    import nv_nvdla_csb2apb_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE      = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned TO_W           = 8
) (
    input  logic                  pclk,
    input  logic                  prstn,
    input  logic                  csb2apb_valid,
    output logic                  csb2apb_ready,
    input  logic [CSB_ADDR_W-1:0] csb2apb_addr,
    input  logic [DATA_W-1:0]     csb2apb_wdat,
    input  logic                  csb2apb_write,
    input  logic                  csb2apb_nposted,
    output logic                  apb2csb_valid,
    output logic [DATA_W-1:0]     apb2csb_data,
    output logic                  apb2csb_wr_complete,
    output logic                  apb2csb_err,
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [APB_ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0]     pwdata,
    input  logic [DATA_W-1:0]     prdata,
    input  logic                  pready,
    input  logic                  pslverr
);

    state_t state;
    logic   req_nposted;
    logic   expired;

    nv_nvdla_csb2apb_tmo #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TO_W           (TO_W)
    ) u_tmo (
        .pclk    (pclk),
        .prstn   (prstn),
        .clear   (state == StSetup),
        .enable  (state == StAccess),
        .expired (expired)
    );

    assign csb2apb_ready = (state == StIdle);

    // Bridge FSM; all APB and response outputs are registered here.
    always_ff @(posedge pclk) begin
        if (!prstn) begin
            state               <= StIdle;
            req_nposted         <= 1'b0;
            psel                <= 1'b0;
            penable             <= 1'b0;
            pwrite              <= 1'b0;
            paddr               <= '0;
            pwdata              <= '0;
            apb2csb_valid       <= 1'b0;
            apb2csb_data        <= '0;
            apb2csb_wr_complete <= 1'b0;
            apb2csb_err         <= 1'b0;
        end else begin
            // Response strobes last exactly one cycle.
            apb2csb_valid       <= 1'b0;
            apb2csb_wr_complete <= 1'b0;
            apb2csb_err         <= 1'b0;

            unique case (state)
                StIdle: begin
                    if (csb2apb_valid) begin
                        paddr       <= csb_to_paddr(ADDR_BASE, csb2apb_addr);
                        pwdata      <= csb2apb_wdat;
                        pwrite      <= csb2apb_write;
                        req_nposted <= csb2apb_nposted;
                        psel        <= 1'b1;
                        penable     <= 1'b0;
                        state       <= StSetup;
                    end
                end
                StSetup: begin
                    penable <= 1'b1;
                    state   <= StAccess;
                end
                StAccess: begin
                    // pready takes priority over an expiry in the same cycle.
                    if (pready) begin
                        psel    <= 1'b0;
                        penable <= 1'b0;
                        state   <= StIdle;
                        if (!pwrite) begin
                            apb2csb_valid <= 1'b1;
                            apb2csb_data  <= prdata;
                            apb2csb_err   <= pslverr;
                        end else if (req_nposted) begin
                            apb2csb_wr_complete <= 1'b1;
                            apb2csb_err         <= pslverr;
                        end
                    end else if (expired) begin
                        psel    <= 1'b0;
                        penable <= 1'b0;
                        state   <= StIdle;
                        if (!pwrite) begin
                            apb2csb_valid <= 1'b1;
                            apb2csb_data  <= '0;
                            apb2csb_err   <= 1'b1;
                        end else if (req_nposted) begin
                            apb2csb_wr_complete <= 1'b1;
                            apb2csb_err         <= 1'b1;
                        end
                    end
                end
                default: begin
                    psel    <= 1'b0;
                    penable <= 1'b0;
                    state   <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nv_nvdla_csb2apb.sv
// Randomized self-checking bench for the CSB-to-APB bridge.
// Unit 0 uses the default timeout; unit 1 uses a 4-cycle timeout and a nonzero base.
module tb_nv_nvdla_csb2apb;

    localparam int unsigned TMO0  = 255;
    localparam int unsigned TMO1  = 4;
    localparam logic [31:0] BASE0 = 32'h0000_0000;
    localparam logic [31:0] BASE1 = 32'h0004_0000;

    typedef struct {
        logic        write;
        logic        np;
        logic [15:0] addr;
        logic [31:0] wdat;
    } req_t;

    logic        pclk = 1'b0;
    logic        prstn_s   [2];
    logic        valid_s   [2];
    logic        ready_s   [2];
    logic [15:0] addr_s    [2];
    logic [31:0] wdat_s    [2];
    logic        write_s   [2];
    logic        np_s      [2];
    logic        rvalid_s  [2];
    logic [31:0] rdata_s   [2];
    logic        wc_s      [2];
    logic        err_s     [2];
    logic        psel_s    [2];
    logic        penable_s [2];
    logic        pwrite_s  [2];
    logic [31:0] paddr_s   [2];
    logic [31:0] pwdata_s  [2];
    logic [31:0] prdata_s  [2];
    logic        pready_s  [2];
    logic        pslverr_s [2];

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] last_data [2];

    always #5 pclk = ~pclk;

    nv_nvdla_csb2apb #(
        .ADDR_BASE      (BASE0),
        .TIMEOUT_CYCLES (TMO0),
        .TO_W           (8)
    ) u_dut0 (
        .pclk                (pclk),
        .prstn               (prstn_s[0]),
        .csb2apb_valid       (valid_s[0]),
        .csb2apb_ready       (ready_s[0]),
        .csb2apb_addr        (addr_s[0]),
        .csb2apb_wdat        (wdat_s[0]),
        .csb2apb_write       (write_s[0]),
        .csb2apb_nposted     (np_s[0]),
        .apb2csb_valid       (rvalid_s[0]),
        .apb2csb_data        (rdata_s[0]),
        .apb2csb_wr_complete (wc_s[0]),
        .apb2csb_err         (err_s[0]),
        .psel                (psel_s[0]),
        .penable             (penable_s[0]),
        .pwrite              (pwrite_s[0]),
        .paddr               (paddr_s[0]),
        .pwdata              (pwdata_s[0]),
        .prdata              (prdata_s[0]),
        .pready              (pready_s[0]),
        .pslverr             (pslverr_s[0])
    );

    nv_nvdla_csb2apb #(
        .ADDR_BASE      (BASE1),
        .TIMEOUT_CYCLES (TMO1),
        .TO_W           (3)
    ) u_dut1 (
        .pclk                (pclk),
        .prstn               (prstn_s[1]),
        .csb2apb_valid       (valid_s[1]),
        .csb2apb_ready       (ready_s[1]),
        .csb2apb_addr        (addr_s[1]),
        .csb2apb_wdat        (wdat_s[1]),
        .csb2apb_write       (write_s[1]),
        .csb2apb_nposted     (np_s[1]),
        .apb2csb_valid       (rvalid_s[1]),
        .apb2csb_data        (rdata_s[1]),
        .apb2csb_wr_complete (wc_s[1]),
        .apb2csb_err         (err_s[1]),
        .psel                (psel_s[1]),
        .penable             (penable_s[1]),
        .pwrite              (pwrite_s[1]),
        .paddr               (paddr_s[1]),
        .pwdata              (pwdata_s[1]),
        .prdata              (prdata_s[1]),
        .pready              (pready_s[1]),
        .pslverr             (pslverr_s[1])
    );

    task automatic check_eq(input string tag, input int u, input logic [31:0] got,
                            input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s unit%0d: got %h expected %h (t=%0t)", tag, u, got, exp, $time);
        end
    endtask

    function automatic int unsigned tmo_of(input int u);
        return (u == 0) ? TMO0 : TMO1;
    endfunction

    function automatic logic [31:0] base_of(input int u);
        return (u == 0) ? BASE0 : BASE1;
    endfunction

    function automatic req_t rand_req();
        req_t r;
        r.write = 1'($urandom_range(0, 1));
        r.np    = 1'($urandom_range(0, 1));
        r.addr  = 16'($urandom);
        r.wdat  = $urandom;
        return r;
    endfunction

    task automatic drive_req(input int u, input req_t r);
        valid_s[u] = 1'b1;
        write_s[u] = r.write;
        np_s[u]    = r.np;
        addr_s[u]  = r.addr;
        wdat_s[u]  = r.wdat;
    endtask

    // No response strobe, err low, read data holding its last value.
    task automatic check_quiet(input int u);
        check_eq("quiet_valid", u, 32'(rvalid_s[u]), 32'd0);
        check_eq("quiet_wc", u, 32'(wc_s[u]), 32'd0);
        check_eq("quiet_err", u, 32'(err_s[u]), 32'd0);
        check_eq("quiet_data", u, rdata_s[u], last_data[u]);
    endtask

    task automatic check_apb(input string tag, input int u, input req_t r, input logic en);
        logic [31:0] exp_addr;
        exp_addr = base_of(u) + (32'(r.addr) * 4);
        check_eq({tag, "_ready"}, u, 32'(ready_s[u]), 32'd0);
        check_eq({tag, "_psel"}, u, 32'(psel_s[u]), 32'd1);
        check_eq({tag, "_penable"}, u, 32'(penable_s[u]), 32'(en));
        check_eq({tag, "_paddr"}, u, paddr_s[u], exp_addr);
        check_eq({tag, "_pwrite"}, u, 32'(pwrite_s[u]), 32'(r.write));
        check_eq({tag, "_pwdata"}, u, pwdata_s[u], r.wdat);
    endtask

    // Starts #1 after a posedge with the DUT idle; ends in the response cycle.
    // waits = wait states before pready; hold presents nxt while busy.
    task automatic do_txn(input int u, input req_t r, input int waits,
                          input logic [31:0] rdata, input logic slverr,
                          input bit hold, input req_t nxt);
        int unsigned tmo;
        int          n;
        bit          timed_out;
        logic        exp_v, exp_wc, exp_err;
        tmo       = tmo_of(u);
        timed_out = (tmo != 0) && (waits + 1 > int'(tmo));
        n         = timed_out ? int'(tmo) : waits + 1;

        check_eq("req_ready", u, 32'(ready_s[u]), 32'd1);
        drive_req(u, r);
        @(posedge pclk);
        #1;
        if (hold) drive_req(u, nxt);
        else valid_s[u] = 1'b0;
        check_apb("setup", u, r, 1'b0);
        check_quiet(u);
        pready_s[u] = 1'b0;
        @(posedge pclk);
        #1;
        for (int k = 1; k <= n; k++) begin
            check_apb("access", u, r, 1'b1);
            check_quiet(u);
            pready_s[u]  = (k == waits + 1);
            prdata_s[u]  = rdata;
            pslverr_s[u] = slverr;
            @(posedge pclk);
            #1;
            pready_s[u]  = 1'b0;
            prdata_s[u]  = $urandom;
            pslverr_s[u] = 1'($urandom_range(0, 1));
        end

        exp_v   = !r.write;
        exp_wc  = r.write && r.np;
        exp_err = (exp_v || exp_wc) && (timed_out || slverr);
        if (exp_v) last_data[u] = timed_out ? 32'd0 : rdata;
        check_eq("rsp_ready", u, 32'(ready_s[u]), 32'd1);
        check_eq("rsp_psel", u, 32'(psel_s[u]), 32'd0);
        check_eq("rsp_penable", u, 32'(penable_s[u]), 32'd0);
        check_eq("rsp_valid", u, 32'(rvalid_s[u]), 32'(exp_v));
        check_eq("rsp_wc", u, 32'(wc_s[u]), 32'(exp_wc));
        check_eq("rsp_err", u, 32'(err_s[u]), 32'(exp_err));
        check_eq("rsp_data", u, rdata_s[u], last_data[u]);
    endtask

    task automatic idle(input int u, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(posedge pclk);
            #1;
            check_eq("idle_ready", u, 32'(ready_s[u]), 32'd1);
            check_eq("idle_psel", u, 32'(psel_s[u]), 32'd0);
            check_quiet(u);
        end
    endtask

    task automatic check_reset_state(input int u);
        check_eq("rst_ready", u, 32'(ready_s[u]), 32'd1);
        check_eq("rst_psel", u, 32'(psel_s[u]), 32'd0);
        check_eq("rst_penable", u, 32'(penable_s[u]), 32'd0);
        check_eq("rst_pwrite", u, 32'(pwrite_s[u]), 32'd0);
        check_eq("rst_paddr", u, paddr_s[u], 32'd0);
        check_eq("rst_pwdata", u, pwdata_s[u], 32'd0);
        last_data[u] = 32'd0;
        check_quiet(u);
    endtask

    // Reset hits while the bridge is in its access phase; the request is dropped.
    task automatic reset_in_access(input int u, input req_t r, input int extra);
        drive_req(u, r);
        @(posedge pclk);
        #1;
        valid_s[u] = 1'b0;
        @(posedge pclk);
        #1;
        for (int i = 0; i < extra; i++) begin
            @(posedge pclk);
            #1;
        end
        check_eq("pre_rst_penable", u, 32'(penable_s[u]), 32'd1);
        prstn_s[u] = 1'b0;
        @(posedge pclk);
        #1;
        prstn_s[u] = 1'b1;
        check_reset_state(u);
        idle(u, 2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        req_t a, b, cur, nxt;
        bit   hold;
        for (int u = 0; u < 2; u++) begin
            prstn_s[u]   = 1'b0;
            valid_s[u]   = 1'b0;
            addr_s[u]    = '0;
            wdat_s[u]    = '0;
            write_s[u]   = 1'b0;
            np_s[u]      = 1'b0;
            prdata_s[u]  = '0;
            pready_s[u]  = 1'b0;
            pslverr_s[u] = 1'b0;
            last_data[u] = '0;
        end
        repeat (2) @(posedge pclk);
        #1;
        for (int u = 0; u < 2; u++) begin
            check_reset_state(u);
            prstn_s[u] = 1'b1;
        end

        // Read, pready on first access cycle.
        a = '{write: 1'b0, np: 1'b0, addr: 16'h0012, wdat: 32'h0};
        do_txn(0, a, 0, 32'hCAFE_0001, 1'b0, 1'b0, a);
        check_eq("t1_paddr_abs", 0, paddr_s[0], 32'h0000_0048);
        idle(0, 1);

        // Non-posted write, 4 wait states, slave error.
        a = '{write: 1'b1, np: 1'b1, addr: 16'h0003, wdat: 32'h1234_5678};
        do_txn(0, a, 4, 32'hDEAD_BEEF, 1'b1, 1'b0, a);
        idle(0, 1);

        // Posted write with slave error, read held valid while busy.
        a = '{write: 1'b1, np: 1'b0, addr: 16'h00A0, wdat: 32'h5555_AAAA};
        b = '{write: 1'b0, np: 1'b0, addr: 16'h00A4, wdat: 32'h0};
        do_txn(0, a, 1, 32'h0, 1'b1, 1'b1, b);
        do_txn(0, b, 0, 32'h0BAD_F00D, 1'b0, 1'b0, b);
        idle(0, 1);

        // Timeout with pready stuck low, then pready in the last allowed cycle.
        a = '{write: 1'b0, np: 1'b0, addr: 16'h0100, wdat: 32'h0};
        do_txn(1, a, 20, 32'h1111_2222, 1'b0, 1'b0, a);
        idle(1, 1);
        do_txn(1, a, 3, 32'h3333_4444, 1'b0, 1'b0, a);
        idle(1, 1);
        a = '{write: 1'b1, np: 1'b1, addr: 16'h0101, wdat: 32'h7777_8888};
        do_txn(1, a, 9, 32'h0, 1'b0, 1'b0, a);
        idle(1, 1);

        // Reset during access, then a normal read.
        a = '{write: 1'b0, np: 1'b0, addr: 16'h0040, wdat: 32'h0};
        reset_in_access(0, a, 1);
        do_txn(0, a, 2, 32'h9ABC_DEF0, 1'b0, 1'b0, a);
        idle(0, 1);
        reset_in_access(1, a, 0);
        do_txn(1, a, 0, 32'h2468_ACE0, 1'b0, 1'b0, a);
        idle(1, 1);

        // Randomized traffic on both units.
        for (int u = 0; u < 2; u++) begin
            cur = rand_req();
            for (int i = 0; i < 30; i++) begin
                nxt  = rand_req();
                hold = (i != 29) && ($urandom_range(0, 1) == 1);
                do_txn(u, cur, int'($urandom_range(0, 7)), $urandom,
                       1'($urandom_range(0, 1)), hold, nxt);
                if (!hold) idle(u, int'($urandom_range(0, 2)));
                cur = nxt;
            end
            idle(u, 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
